// File: rtl/cba_region_pkg.sv
// Shared types and constants for the CBA core-region hit collector.
// The entry struct is sized from the CBA_* constants below. Any instance of
// cba_region_hit_collector must keep its parameters equal to these constants.
`ifndef CBA_TOT_BITS
`define CBA_TOT_BITS 4
`endif

package cba_region_pkg;

   localparam int CBA_NPIX     = 4;
   localparam int CBA_TOT_BITS = `CBA_TOT_BITS;
   localparam int CBA_DEPTH    = 8;
   localparam int CBA_TS_BITS  = 9;
   localparam int CBA_TAG_BITS = 5;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      ACQ  = 2'd1,
      WAIT = 2'd2,
      TRIG = 2'd3
   } entry_state_t;

   // All-ones ToT marks a pixel whose ToT never arrived.
   function automatic int unsigned tot_not_saved(input int unsigned tot_bits);
      return (32'd1 << tot_bits) - 32'd1;
   endfunction

   // The front end saturates ToT one below the marker, so the two never collide.
   function automatic int unsigned tot_ovf(input int unsigned tot_bits);
      return (32'd1 << tot_bits) - 32'd2;
   endfunction

   typedef struct packed {
      entry_state_t                       state;
      logic [CBA_TS_BITS-1:0]             ts;
      logic [CBA_TAG_BITS-1:0]            tag;
      logic [CBA_NPIX-1:0]                hitmap;
      logic [CBA_NPIX-1:0]                saved;
      logic [CBA_NPIX*CBA_TOT_BITS-1:0]   tot;
   } entry_t;

endpackage

// File: rtl/cba_region_idx_fifo.sv
// Small synchronous FIFO of latency-buffer indices, kept in trigger order.
// It cannot overflow because it only ever holds indices of TRIG entries.
module cba_region_idx_fifo #(
   parameter int DEPTH = 8,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          ClkDig,
   input  logic          Reset,
   input  logic          push,
   input  logic [IW-1:0] push_idx,
   input  logic          pop,
   output logic [IW-1:0] head,
   output logic          empty
);

   logic [IW-1:0] mem [DEPTH];
   logic [IW:0]   wr_ptr;
   logic [IW:0]   rd_ptr;

   localparam logic [IW:0] PTR_ONE = {{IW{1'b0}}, 1'b1};

   // Storage and the wrap-extended read/write pointers.
   always_ff @(posedge ClkDig or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr[IW-1:0]] <= push_idx;
            wr_ptr              <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   assign head  = mem[rd_ptr[IW-1:0]];
   assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/cba_region_hit_collector.sv
// Region hit collector: timestamps hit events, gathers per-pixel ToT, holds
// each event until Bcid reaches ts+Latency, and keeps triggered events for
// valid/ready readout in trigger order.
// Optional build macro CBA_REGION_TS_OUT_EN prepends the entry timestamp to DataOut.
module cba_region_hit_collector
   import cba_region_pkg::*;
#(
   parameter int NPIX     = CBA_NPIX,
   parameter int TOT_BITS = CBA_TOT_BITS,
   parameter int DEPTH    = CBA_DEPTH,
   parameter int TS_BITS  = CBA_TS_BITS,
   parameter int TAG_BITS = CBA_TAG_BITS
) (
   input  logic                      ClkDig,
   input  logic                      Reset,
   input  logic [NPIX-1:0]           PresentPulse,
   input  logic [NPIX-1:0]           TotSavePulse,
   input  logic [NPIX*TOT_BITS-1:0]  ToT,
   input  logic [TS_BITS-1:0]        Bcid,
   input  logic [TS_BITS-1:0]        Latency,
   input  logic                      Trigger,
   input  logic [TAG_BITS-1:0]       TrigTag,
   output logic                      DataValid,
   input  logic                      DataReady,
`ifdef CBA_REGION_TS_OUT_EN
   output logic [TS_BITS+TAG_BITS+NPIX+NPIX*TOT_BITS-1:0] DataOut,
`else
   output logic [TAG_BITS+NPIX+NPIX*TOT_BITS-1:0]         DataOut,
`endif
   output logic                      Full,
   output logic [7:0]                OverflowCnt
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [TOT_BITS-1:0] TOT_NS = TOT_BITS'(tot_not_saved(TOT_BITS));

   entry_t        ent      [DEPTH];
   entry_t        ent_n    [DEPTH];
   logic [NPIX-1:0] own_v;
   logic [NPIX-1:0] own_v_n;
   logic [IW-1:0] own_i    [NPIX];
   logic [IW-1:0] own_i_n  [NPIX];
   logic [7:0]    ovf_n;
   logic          full_n;
   logic          alloc_found;
   logic [IW-1:0] alloc_idx;
   logic          push;
   logic [IW-1:0] push_idx;
   logic          pop;
   logic [IW-1:0] fifo_head;
   logic          fifo_empty;

   cba_region_idx_fifo #(
      .DEPTH (DEPTH)
   ) u_idx_fifo (
      .ClkDig   (ClkDig),
      .Reset    (Reset),
      .push     (push),
      .push_idx (push_idx),
      .pop      (pop),
      .head     (fifo_head),
      .empty    (fifo_empty)
   );

   // State register for the entries, pixel owner pointers and status outputs.
   always_ff @(posedge ClkDig or posedge Reset) begin
      if (Reset) begin
         for (int e = 0; e < DEPTH; e++) begin
            ent[e] <= '0;
         end
         for (int p = 0; p < NPIX; p++) begin
            own_i[p] <= '0;
         end
         own_v       <= '0;
         OverflowCnt <= '0;
         Full        <= 1'b0;
      end else begin
         ent         <= ent_n;
         own_v       <= own_v_n;
         own_i       <= own_i_n;
         OverflowCnt <= ovf_n;
         Full        <= full_n;
      end
   end

   // Next state: ToT saves, then latency match, then readout pop, then allocation.
   always_comb begin
      ent_n       = ent;
      own_v_n     = own_v;
      own_i_n     = own_i;
      ovf_n       = OverflowCnt;
      push        = 1'b0;
      push_idx    = '0;
      alloc_found = 1'b0;
      alloc_idx   = '0;
      full_n      = 1'b1;
      pop         = !fifo_empty && DataReady;

      for (int p = 0; p < NPIX; p++) begin
         if (TotSavePulse[p] && own_v[p]) begin
            ent_n[own_i[p]].tot[p*TOT_BITS +: TOT_BITS] = ToT[p*TOT_BITS +: TOT_BITS];
            ent_n[own_i[p]].saved[p] = 1'b1;
            own_v_n[p] = 1'b0;
         end
      end

      for (int e = 0; e < DEPTH; e++) begin
         if ((ent[e].state == ACQ || ent[e].state == WAIT) &&
             (Bcid == TS_BITS'(ent[e].ts + Latency))) begin
            if (Trigger) begin
               ent_n[e].state = TRIG;
               ent_n[e].tag   = TrigTag;
               push           = 1'b1;
               push_idx       = IW'(e);
            end else begin
               ent_n[e].state = FREE;
            end
            for (int p = 0; p < NPIX; p++) begin
               if (own_v_n[p] && own_i_n[p] == IW'(e)) begin
                  own_v_n[p] = 1'b0;
               end
            end
         end else if (ent[e].state == ACQ &&
                      (ent_n[e].saved & ent[e].hitmap) == ent[e].hitmap) begin
            ent_n[e].state = WAIT;
         end
      end

      if (pop) begin
         ent_n[fifo_head].state = FREE;
      end

      for (int e = DEPTH - 1; e >= 0; e--) begin
         if (ent[e].state == FREE) begin
            alloc_found = 1'b1;
            alloc_idx   = IW'(e);
         end
      end

      if (|PresentPulse) begin
         if (alloc_found) begin
            ent_n[alloc_idx] = '{state:  ACQ,
                                 ts:     Bcid,
                                 tag:    '0,
                                 hitmap: PresentPulse,
                                 saved:  '0,
                                 tot:    {NPIX{TOT_NS}}};
            for (int p = 0; p < NPIX; p++) begin
               if (PresentPulse[p]) begin
                  own_v_n[p] = 1'b1;
                  own_i_n[p] = alloc_idx;
               end
            end
         end else begin
            if (OverflowCnt != 8'hFF) begin
               ovf_n = OverflowCnt + 8'd1;
            end
            for (int p = 0; p < NPIX; p++) begin
               if (PresentPulse[p]) begin
                  own_v_n[p] = 1'b0;
               end
            end
         end
      end

      for (int e = 0; e < DEPTH; e++) begin
         if (ent_n[e].state == FREE) begin
            full_n = 1'b0;
         end
      end
   end

   // Readout word: FIFO head entry, zero when nothing is waiting.
   always_comb begin
      DataValid = !fifo_empty;
      DataOut   = '0;
      if (!fifo_empty) begin
`ifdef CBA_REGION_TS_OUT_EN
         DataOut = {ent[fifo_head].ts, ent[fifo_head].tag,
                    ent[fifo_head].hitmap, ent[fifo_head].tot};
`else
         DataOut = {ent[fifo_head].tag, ent[fifo_head].hitmap, ent[fifo_head].tot};
`endif
      end
   end

endmodule
